count_capture_fifo: RTL
=======================

COUNT_CAPTURE_FIFO -- requirements
Module: count_capture_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of the sampled count and of each FIFO entry.
REQ-002 SHALL have parameter DEPTH, default 4: number of FIFO entries; a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port count, input, WIDTH bits: the free-running counter value from the upstream counter stage.
REQ-006 SHALL have port capture, input, 1 bit: request to store the current count this cycle.
REQ-007 SHALL have port out_data, output, WIDTH bits: the oldest stored entry (show-ahead).
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-010 SHALL have port level, output, log2(DEPTH)+1 bits: number of stored entries.
REQ-011 SHALL have ports full and empty, output, 1 bit each: level==DEPTH and level==0 respectively.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag for a dropped capture.

Function
REQ-013 SHALL define push as a capture request that is accepted, i.e. (!full || pop); pop as out_valid && out_ready.
REQ-014 SHALL write count into the tail entry on a push, at the same clk edge; the stored value is the count present in that cycle.
REQ-015 SHALL advance the head on a pop; out_data and out_valid SHALL update on the following cycle from the next entry.
REQ-016 SHALL have write-to-read latency of exactly 1 cycle: push into an empty FIFO asserts out_valid on the next cycle; no combinational bypass from count to out_data.
REQ-017 SHALL drive out_valid = !empty; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 SHALL accept both operations on simultaneous push and pop with level unchanged, including when full.
REQ-019 SHALL perform no pop on out_ready=1 while empty, with level remaining 0.
REQ-020 SHALL drop a capture when full with no pop, leave level unchanged, and set overflow from the next cycle until reset.
REQ-021 SHALL wrap read and write pointers modulo DEPTH; level SHALL saturate at neither 0 nor DEPTH by underflow or overflow.
REQ-022 SHALL keep level = pushes - pops at every cycle, with 0 <= level <= DEPTH.

Reset
REQ-023 SHALL, while reset=0, asynchronously force: pointers=0, level=0, empty=1, full=0, out_valid=0, out_data=0, overflow=0, and the wrap-detect register=0.
REQ-024 SHALL discard all stored entries when reset is asserted mid-operation; the first capture after release SHALL appear as the first out_data.
REQ-025 SHALL treat reset deassertion as synchronous release: the first push SHALL be accepted on the first rising clk edge with reset=1.

Configuration
REQ-026 SHALL use macro COUNT_CAPTURE_WRAP_EN to control wrap-triggered auto-capture, as given in REQ-027 and REQ-028.
REQ-027 SHALL, when COUNT_CAPTURE_WRAP_EN is defined, register count each cycle and treat (previous count == all-ones && count == 0) as an additional capture request, ORed with capture; the stored value is 0.
REQ-028 SHALL, when COUNT_CAPTURE_WRAP_EN is undefined, omit the previous-count register; only the capture input pushes.

Verification
REQ-029 SHALL cover basic capture: reset released, capture pulsed with count=3, then 7 -> out_valid=1 one cycle later; out_data=3, and after one pop out_data=7; level 2->1->0.
REQ-030 SHALL cover backpressure: 4 captures (count=1,2,3,4) with out_ready=0 -> full=1, level=4; out_data held at 1; 5th capture (count=5) -> dropped, overflow=1.
REQ-031 SHALL cover push and pop when full: full FIFO with capture=1 (count=9) and out_ready=1 -> level stays 4, 9 is stored last; drained order is 2,3,4,9.
REQ-032 SHALL cover mid-operation reset: level=3, then reset=0 for 1 cycle -> level=0, out_valid=0, overflow=0; capture count=6 -> out_data=6.
REQ-033 SHALL cover wrap: with COUNT_CAPTURE_WRAP_EN and count stepping 14,15,0 with capture=0 -> exactly one entry with value 0; without the macro -> level stays 0.
REQ-034 SHALL cover pointer wrap-around: 10 push/pop pairs with count=0..9 -> outputs 0..9 in order; empty=1 at the end.

Source files
------------

// File: rtl/count_capture_fifo.sv
// count_capture_fifo: captures a free-running counter value into a small
// show-ahead FIFO on request. Write-to-read latency is one cycle. A capture
// that finds the FIFO full with no pop is dropped and sets a sticky overflow flag.
// Optional feature: define COUNT_CAPTURE_WRAP_EN to also capture the count
// automatically when it wraps from all-ones to zero.
module count_capture_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic             capture,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0]               r_wr_ptr;
  logic [AW-1:0]               r_rd_ptr;
  logic [AW:0]                 r_level;
  logic                        r_overflow;
  logic                        w_cap_req;
  logic                        w_push;
  logic                        w_pop;

`ifdef COUNT_CAPTURE_WRAP_EN
  logic [WIDTH-1:0] r_prev_count;

  // Previous count, used to spot the all-ones -> zero wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_prev_count <= '0;
    else        r_prev_count <= count;
  end

  // A wrap counts as a capture; the stored value is then count, i.e. zero.
  assign w_cap_req = capture || ((r_prev_count == {WIDTH{1'b1}}) && (count == '0));
`else
  assign w_cap_req = capture;
`endif

  assign empty     = (r_level == '0);
  assign full      = (r_level == (AW+1)'(DEPTH));
  assign out_valid = !empty;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign w_pop     = out_valid && out_ready;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign w_push    = w_cap_req && (!full || w_pop);
  // Show-ahead: head entry is visible directly; zero when nothing is stored.
  assign out_data  = empty ? '0 : r_mem[r_rd_ptr];

  // Entry storage: write the current count at the tail on a push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_mem <= '0;
    else if (w_push) r_mem[r_wr_ptr] <= count;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Occupancy: pushes minus pops; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overflow: set by a capture dropped on a full FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             r_overflow <= 1'b0;
    else if (w_cap_req && full && !w_pop)   r_overflow <= 1'b1;
  end

endmodule
